ysyx_22041412_div_iter: RTL and testbench

Iterative radix-2 restoring divider; the responder for the ALU's divide request/valid interface.
- ALU drives dividend/divisor plus div_valid/divw/div_signed/div_mode; block returns out_valid and div_result.
- Implements RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW, including RISC-V divide-by-zero and overflow semantics.
- Sits inside the EX stage, beside the multiplier.

---
 rtl/ysyx_22041412_div_pkg.sv | 34 +++
 rtl/ysyx_22041412_div_signfix.sv | 80 ++++++++
 rtl/ysyx_22041412_div_iter.sv | 216 +++++++++++++++++++++
 tb/tb_ysyx_22041412_div_iter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041412_div_pkg.sv
// Shared widths, FSM encoding and small arithmetic helpers for the iterative divider.
package ysyx_22041412_div_pkg;

  localparam int XLEN  = 64;
  localparam int WLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [CNT_W-1:0] CNT_XLEN = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_WLEN = CNT_W'(WLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] XZERO      = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] XONE       = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] XMIN       = {1'b1, {(XLEN-1){1'b0}}};
  // Most-negative word value after sign extension to XLEN.
  localparam logic [XLEN-1:0] WMIN_EXT   = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return (~v) + XONE;
  endfunction

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
  endfunction

endpackage

// File: rtl/ysyx_22041412_div_signfix.sv
// Combinational operand conditioning (width select, extension, magnitudes, special-case
// detection) and final result correction (negation, special-case forcing, word sign-extension).
module ysyx_22041412_div_signfix
  import ysyx_22041412_div_pkg::*;
(
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            divw,
  input  logic            div_signed,
  output logic [XLEN-1:0] a_ext,
  output logic [XLEN-1:0] a_mag,
  output logic [XLEN-1:0] b_mag,
  output logic            q_neg,
  output logic            r_neg,
  output logic            div_zero,
  output logic            div_ovf,
  input  logic [XLEN-1:0] quot_raw,
  input  logic [XLEN-1:0] rem_raw,
  input  logic [XLEN-1:0] fix_a_ext,
  input  logic            fix_q_neg,
  input  logic            fix_r_neg,
  input  logic            fix_zero,
  input  logic            fix_ovf,
  input  logic            fix_mode,
  input  logic            fix_divw,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] b_ext_s;
  logic            sa_s;
  logic            sb_s;
  logic [XLEN-1:0] q_fix_s;
  logic [XLEN-1:0] r_fix_s;
  logic [XLEN-1:0] sel_s;

  // Operand extension, magnitudes and special-case flags for an incoming request.
  always_comb begin
    a_ext   = dividend;
    b_ext_s = divisor;
    if (divw) begin
      if (div_signed) begin
        a_ext   = sext_w(dividend);
        b_ext_s = sext_w(divisor);
      end else begin
        a_ext   = {{(XLEN-WLEN){1'b0}}, dividend[WLEN-1:0]};
        b_ext_s = {{(XLEN-WLEN){1'b0}}, divisor[WLEN-1:0]};
      end
    end else begin
      a_ext   = dividend;
      b_ext_s = divisor;
    end
    sa_s     = div_signed & a_ext[XLEN-1];
    sb_s     = div_signed & b_ext_s[XLEN-1];
    a_mag    = sa_s ? neg_x(a_ext) : a_ext;
    b_mag    = sb_s ? neg_x(b_ext_s) : b_ext_s;
    q_neg    = sa_s ^ sb_s;
    r_neg    = sa_s;
    div_zero = (b_ext_s == XZERO);
    div_ovf  = div_signed & (a_ext == (divw ? WMIN_EXT : XMIN)) & (b_ext_s == DIV_ZERO_Q);
  end

  // Sign correction of the raw quotient/remainder, RISC-V special cases, then word narrowing.
  always_comb begin
    q_fix_s = fix_q_neg ? neg_x(quot_raw) : quot_raw;
    r_fix_s = fix_r_neg ? neg_x(rem_raw) : rem_raw;
    if (fix_zero) begin
      q_fix_s = DIV_ZERO_Q;
      r_fix_s = fix_a_ext;
    end else if (fix_ovf) begin
      q_fix_s = fix_a_ext;
      r_fix_s = XZERO;
    end else begin
      q_fix_s = fix_q_neg ? neg_x(quot_raw) : quot_raw;
      r_fix_s = fix_r_neg ? neg_x(rem_raw) : rem_raw;
    end
    sel_s  = fix_mode ? r_fix_s : q_fix_s;
    result = fix_divw ? sext_w(sel_s) : sel_s;
  end

endmodule

// File: rtl/ysyx_22041412_div_iter.sv
// Iterative radix-2 restoring divider for RV64M divide/remainder (word and doubleword).
// Optional YSYX_22041412_DIV_FAST_EN: trivial cases (zero divisor, overflow, |a|<|b|) finish in one cycle.
module ysyx_22041412_div_iter
  import ysyx_22041412_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            div_valid,
  input  logic            divw,
  input  logic            div_signed,
  input  logic            div_mode,
  output logic            div_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] div_result
);

  div_state_e      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0] quot_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] b_r;
  logic [XLEN-1:0] a_ext_r;
  logic            q_neg_r;
  logic            r_neg_r;
  logic            zero_r;
  logic            ovf_r;
  logic            mode_r;
  logic            divw_r;
  logic            ready_r;
  logic            out_valid_r;
  logic [XLEN-1:0] div_result_r;

  logic [XLEN-1:0] cap_a_ext_s;
  logic [XLEN-1:0] cap_a_mag_s;
  logic [XLEN-1:0] cap_b_mag_s;
  logic            cap_q_neg_s;
  logic            cap_r_neg_s;
  logic            cap_zero_s;
  logic            cap_ovf_s;

  logic [XLEN:0]   rem_sh_s;
  logic [XLEN:0]   diff_s;
  logic [XLEN-1:0] rem_nxt_s;
  logic [XLEN-1:0] quot_nxt_s;

  logic [XLEN-1:0] fx_quot_s;
  logic [XLEN-1:0] fx_rem_s;
  logic [XLEN-1:0] fx_a_ext_s;
  logic            fx_q_neg_s;
  logic            fx_r_neg_s;
  logic            fx_zero_s;
  logic            fx_ovf_s;
  logic            fx_mode_s;
  logic            fx_divw_s;
  logic [XLEN-1:0] fx_result_s;

  ysyx_22041412_div_signfix u_signfix (
    .dividend   (dividend),
    .divisor    (divisor),
    .divw       (divw),
    .div_signed (div_signed),
    .a_ext      (cap_a_ext_s),
    .a_mag      (cap_a_mag_s),
    .b_mag      (cap_b_mag_s),
    .q_neg      (cap_q_neg_s),
    .r_neg      (cap_r_neg_s),
    .div_zero   (cap_zero_s),
    .div_ovf    (cap_ovf_s),
    .quot_raw   (fx_quot_s),
    .rem_raw    (fx_rem_s),
    .fix_a_ext  (fx_a_ext_s),
    .fix_q_neg  (fx_q_neg_s),
    .fix_r_neg  (fx_r_neg_s),
    .fix_zero   (fx_zero_s),
    .fix_ovf    (fx_ovf_s),
    .fix_mode   (fx_mode_s),
    .fix_divw   (fx_divw_s),
    .result     (fx_result_s)
  );

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    rem_sh_s = {rem_r, quot_r[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, b_r};
    if (!diff_s[XLEN]) begin
      rem_nxt_s  = diff_s[XLEN-1:0];
      quot_nxt_s = {quot_r[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt_s  = rem_sh_s[XLEN-1:0];
      quot_nxt_s = {quot_r[XLEN-2:0], 1'b0};
    end
  end

  // Result correction sees the incoming request in IDLE (fast finish) or the final step in CALC.
  always_comb begin
    if (state_r == IDLE) begin
      fx_quot_s  = XZERO;
      fx_rem_s   = cap_a_mag_s;
      fx_a_ext_s = cap_a_ext_s;
      fx_q_neg_s = cap_q_neg_s;
      fx_r_neg_s = cap_r_neg_s;
      fx_zero_s  = cap_zero_s;
      fx_ovf_s   = cap_ovf_s;
      fx_mode_s  = div_mode;
      fx_divw_s  = divw;
    end else begin
      fx_quot_s  = quot_nxt_s;
      fx_rem_s   = rem_nxt_s;
      fx_a_ext_s = a_ext_r;
      fx_q_neg_s = q_neg_r;
      fx_r_neg_s = r_neg_r;
      fx_zero_s  = zero_r;
      fx_ovf_s   = ovf_r;
      fx_mode_s  = mode_r;
      fx_divw_s  = divw_r;
    end
  end

`ifdef YSYX_22041412_DIV_FAST_EN
  logic fast_s;
  // Cases whose answer is known without iterating.
  always_comb begin
    fast_s = cap_zero_s | cap_ovf_s | (cap_a_mag_s < cap_b_mag_s);
  end
`endif

  // Divider FSM, iteration counter and shift registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      quot_r       <= XZERO;
      rem_r        <= XZERO;
      b_r          <= XZERO;
      a_ext_r      <= XZERO;
      q_neg_r      <= 1'b0;
      r_neg_r      <= 1'b0;
      zero_r       <= 1'b0;
      ovf_r        <= 1'b0;
      mode_r       <= 1'b0;
      divw_r       <= 1'b0;
      ready_r      <= 1'b1;
      out_valid_r  <= 1'b0;
      div_result_r <= XZERO;
    end else if (flush) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      ready_r     <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          if (div_valid) begin
            cnt_r   <= divw ? CNT_WLEN : CNT_XLEN;
            // Word ops start with the 32-bit magnitude left-aligned so its MSB shifts out first.
            quot_r  <= divw ? {cap_a_mag_s[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : cap_a_mag_s;
            rem_r   <= XZERO;
            b_r     <= cap_b_mag_s;
            a_ext_r <= cap_a_ext_s;
            q_neg_r <= cap_q_neg_s;
            r_neg_r <= cap_r_neg_s;
            zero_r  <= cap_zero_s;
            ovf_r   <= cap_ovf_s;
            mode_r  <= div_mode;
            divw_r  <= divw;
            ready_r <= 1'b0;
`ifdef YSYX_22041412_DIV_FAST_EN
            if (fast_s) begin
              state_r      <= DONE;
              out_valid_r  <= 1'b1;
              div_result_r <= fx_result_s;
            end else begin
              state_r <= CALC;
            end
`else
            state_r <= CALC;
`endif
          end else begin
            ready_r <= 1'b1;
          end
        end
        CALC: begin
          quot_r <= quot_nxt_s;
          rem_r  <= rem_nxt_s;
          cnt_r  <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r      <= DONE;
            out_valid_r  <= 1'b1;
            div_result_r <= fx_result_s;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          ready_r     <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          ready_r     <= 1'b1;
        end
      endcase
    end
  end

  assign div_ready  = ready_r;
  assign out_valid  = out_valid_r;
  assign div_result = div_result_r;

endmodule

// File: tb/tb_ysyx_22041412_div_iter.sv
// Randomized and directed self-checking bench for ysyx_22041412_div_iter against an arithmetic reference.
module tb_ysyx_22041412_div_iter;

`ifdef YSYX_22041412_DIV_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        div_valid;
  logic        divw;
  logic        div_signed;
  logic        div_mode;
  logic        div_ready;
  logic        out_valid;
  logic [63:0] div_result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_22041412_div_iter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_valid  (div_valid),
    .divw       (divw),
    .div_signed (div_signed),
    .div_mode   (div_mode),
    .div_ready  (div_ready),
    .out_valid  (out_valid),
    .div_result (div_result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics computed with plain arithmetic.
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic w, input logic s, input logic m);
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q, r;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q = 64'hFFFF_FFFF_FFFF_FFFF; r = a;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a; r = 64'd0;
      end else if (s) begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end else begin
        q = a / b; r = a % b;
      end
    end
    return m ? r : q;
  endfunction

  // Cycles from the accepting cycle to the out_valid cycle.
  function automatic int exp_lat(input logic [63:0] a, input logic [63:0] b,
                                 input logic w, input logic s);
    logic [63:0] ea, eb, ma, mb;
    logic        trivial;
    ea = w ? (s ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
    eb = w ? (s ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
    ma = (s && ea[63]) ? -ea : ea;
    mb = (s && eb[63]) ? -eb : eb;
    trivial = (eb == 64'd0) || (ma < mb) ||
              (s && eb == 64'hFFFF_FFFF_FFFF_FFFF &&
               ea == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    return (FAST && trivial) ? 1 : (w ? 33 : 65);
  endfunction

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic w, input logic s, input logic m);
    int n;
    logic [63:0] exp;
    exp = ref_div(a, b, w, s, m);
    @(negedge clk);
    check($sformatf("%s ready", tag), {63'd0, div_ready}, 64'd1);
    dividend = a; divisor = b; divw = w; div_signed = s; div_mode = m; div_valid = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s latency", tag), 64'(n), 64'(exp_lat(a, b, w, s)));
    check($sformatf("%s result", tag), div_result, exp);
    @(negedge clk);
    check($sformatf("%s pulse", tag), {63'd0, out_valid}, 64'd0);
    check($sformatf("%s hold", tag), div_result, exp);
  endtask

  task automatic expect_quiet(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    logic [63:0] a, b, held;
    rst = 1'b1; flush = 1'b0; div_valid = 1'b0;
    dividend = 64'd0; divisor = 64'd0; divw = 1'b0; div_signed = 1'b0; div_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset ready", {63'd0, div_ready}, 64'd1);
    check("reset result", div_result, 64'd0);
    rst = 1'b0;

    run_op("divu", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
    run_op("remu", 64'd100, 64'd7, 1'b0, 1'b0, 1'b1);
    run_op("div neg", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 1'b0);
    run_op("rem neg", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 1'b1);
    run_op("divw", 64'h0000_0001_8000_0000, 64'd2, 1'b1, 1'b1, 1'b0);
    run_op("divu zero", 64'd5, 64'd0, 1'b0, 1'b0, 1'b0);
    run_op("remu zero", 64'd5, 64'd0, 1'b0, 1'b0, 1'b1);
    run_op("remuw zero", 64'h0000_0000_8000_0001, 64'd0, 1'b1, 1'b0, 1'b1);
    run_op("div ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op("rem ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
    run_op("divw ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("divuw", 64'h1234_5678_F000_0000, 64'd3, 1'b1, 1'b0, 1'b0);
    run_op("remu small", 64'd3, 64'd10, 1'b0, 1'b0, 1'b1);
    held = ref_div(64'd3, 64'd10, 1'b0, 1'b0, 1'b1);

    // Flush in the middle of CALC discards the operation.
    @(negedge clk);
    dividend = 64'd100; divisor = 64'd7; divw = 1'b0; div_signed = 1'b0; div_mode = 1'b0;
    div_valid = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush ready", {63'd0, div_ready}, 64'd1);
    expect_quiet("flush no out_valid");
    check("flush result held", div_result, held);

    // flush wins over a simultaneous request.
    dividend = 64'd50; divisor = 64'd5; div_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    div_valid = 1'b0; flush = 1'b0;
    check("flush prio ready", {63'd0, div_ready}, 64'd1);
    expect_quiet("flush prio no out_valid");
    run_op("after flush", 64'd9, 64'd3, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of CALC.
    @(negedge clk);
    dividend = 64'd1000; divisor = 64'd9; div_valid = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid reset out_valid", {63'd0, out_valid}, 64'd0);
    check("mid reset ready", {63'd0, div_ready}, 64'd1);
    check("mid reset result", div_result, 64'd0);
    expect_quiet("mid reset no out_valid");

    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom} >> $urandom_range(0, 63);
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) a = -a;
      if ($urandom_range(0, 1) == 1) b = -b;
      if ($urandom_range(0, 9) == 0) b = 64'd0;
      run_op($sformatf("rnd%0d", i), a, b, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
